// File: rtl/code_ram.sv
// Program memory for a small CPU: zero-fills itself after reset, then accepts a
// byte-serial program load (MSB byte first) while the CPU fetches NOPs.
module code_ram #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] addr,
  output logic [DW-1:0] data,
  input  logic          ld_start,
  input  logic          ld_valid,
  input  logic [7:0]    ld_byte,
  input  logic          ld_last,
  output logic          ld_ready,
  output logic          busy,
  output logic          ld_done,
  output logic          ld_ovf
);

  localparam int unsigned NB = DW / 8;
  localparam int unsigned CW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [AW-1:0] PTR_MAX = '1;
  localparam logic [CW-1:0] CNT_MAX = CW'(NB - 1);

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_LOAD,
    ST_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   asm_q, asm_d;
  logic            ld_ovf_q, ld_ovf_d;
  logic            ld_ready_q, ld_ready_d;
  logic            busy_q, busy_d;
  logic            ld_done_q, ld_done_d;

  logic [DW-1:0]   mem_q [2**AW];
  logic            wr_en_c;
  logic [DW-1:0]   wr_data_c;
  logic [DW-1:0]   asm_next_c;
  logic [CW-1:0]   pad_c;

  // Next-state, pointer and memory-write decode
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    asm_d      = asm_q;
    ld_ovf_d   = ld_ovf_q;
    wr_en_c    = 1'b0;
    wr_data_c  = '0;
    asm_next_c = (asm_q << 8) | DW'(ld_byte);
    pad_c      = CNT_MAX - cnt_q;

    case (state_q)
      ST_CLEAR: begin
        wr_en_c = 1'b1;
        if (ptr_q == PTR_MAX) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + AW'(1);
        end
      end
      ST_IDLE: begin
        if (ld_start) begin
          state_d  = ST_LOAD;
          ptr_d    = '0;
          cnt_d    = '0;
          asm_d    = '0;
          ld_ovf_d = 1'b0;
        end
      end
      ST_LOAD: begin
        if (ld_valid && ld_ready_q) begin
          asm_d = asm_next_c;
          cnt_d = cnt_q + CW'(1);
          // Word completes on its last byte, or early on ld_last with zero padding
          if (cnt_q == CNT_MAX || ld_last) begin
            wr_en_c   = 1'b1;
            wr_data_c = asm_next_c << {pad_c, 3'b000};
            cnt_d     = '0;
            asm_d     = '0;
            if (ld_last) begin
              state_d = ST_DONE;
            end else if (ptr_q == PTR_MAX) begin
              state_d  = ST_DONE;
              ld_ovf_d = 1'b1;
            end else begin
              ptr_d = ptr_q + AW'(1);
            end
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_CLEAR;
    endcase

    busy_d     = (state_d != ST_IDLE);
    ld_ready_d = (state_d == ST_LOAD);
    ld_done_d  = (state_d == ST_DONE);
  end

  // Control registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_CLEAR;
      ptr_q      <= '0;
      cnt_q      <= '0;
      asm_q      <= '0;
      ld_ovf_q   <= 1'b0;
      ld_ready_q <= 1'b0;
      busy_q     <= 1'b1;
      ld_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      asm_q      <= asm_d;
      ld_ovf_q   <= ld_ovf_d;
      ld_ready_q <= ld_ready_d;
      busy_q     <= busy_d;
      ld_done_q  <= ld_done_d;
    end
  end

  // Storage array; contents are only ever defined by CLEAR and loads
  always_ff @(posedge clk) begin
    if (!reset && wr_en_c) begin
      mem_q[ptr_q] <= wr_data_c;
    end
  end

  always_comb begin
    data = busy_q ? '0 : mem_q[addr];
  end

  assign ld_ready = ld_ready_q;
  assign busy     = busy_q;
  assign ld_done  = ld_done_q;
  assign ld_ovf   = ld_ovf_q;

endmodule

// File: tb/tb_code_ram.sv
// Randomised bench for code_ram: a default instance and an AW=4/DW=24 instance
// share stimulus and are checked every cycle against a byte-list memory model.
module tb_code_ram;

  logic        clk, reset, ld_start, ld_valid, ld_last;
  logic [7:0]  ld_byte, addr;
  logic [3:0]  addr2;
  logic [15:0] data;
  logic [23:0] data2;
  logic        ld_ready, busy, ld_done, ld_ovf;
  logic        ld_ready2, busy2, ld_done2, ld_ovf2;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  assign addr2 = addr[3:0];

  code_ram dut (
    .clk(clk), .reset(reset), .addr(addr), .data(data),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_last(ld_last),
    .ld_ready(ld_ready), .busy(busy), .ld_done(ld_done), .ld_ovf(ld_ovf)
  );

  code_ram #(.AW(4), .DW(24)) dut2 (
    .clk(clk), .reset(reset), .addr(addr2), .data(data2),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_last(ld_last),
    .ld_ready(ld_ready2), .busy(busy2), .ld_done(ld_done2), .ld_ovf(ld_ovf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: instance 0 is 256 x 16-bit, instance 1 is 16 x 24-bit
  int          m_clear [2];
  bit          m_load  [2];
  bit          m_done  [2];
  bit          m_ovf   [2];
  int          m_n     [2];
  logic [7:0]  m_bytes [2][1024];
  logic [31:0] m_mem   [2][256];
  logic [7:0]  stim    [1024];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got=%h expected=%h", nm, $time, got, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input int i, input int w, input int nb);
    logic [31:0] r = 0;
    for (int k = 0; k < nb; k++) begin
      r = r << 8;
      if (w * nb + k < m_n[i]) r = r | 32'(m_bytes[i][w * nb + k]);
    end
    return r;
  endfunction

  function automatic void model_step(input int i);
    int depth = (i == 0) ? 256 : 16;
    int nb    = (i == 0) ? 2 : 3;
    int w;
    if (reset) begin
      m_clear[i] = depth;
      m_load[i]  = 0;
      m_done[i]  = 0;
      m_ovf[i]   = 0;
      m_n[i]     = 0;
    end else if (m_clear[i] > 0) begin
      m_clear[i]--;
      if (m_clear[i] == 0) for (int a = 0; a < 256; a++) m_mem[i][a] = 0;
    end else if (m_done[i]) begin
      m_done[i] = 0;
    end else if (m_load[i]) begin
      if (ld_valid) begin
        m_bytes[i][m_n[i]] = ld_byte;
        m_n[i]++;
        if ((m_n[i] % nb) == 0 || ld_last) begin
          w = (m_n[i] - 1) / nb;
          m_mem[i][w] = word_of(i, w, nb);
          if (ld_last || w == depth - 1) begin
            m_load[i] = 0;
            m_done[i] = 1;
            m_ovf[i]  = !ld_last;
          end
        end
      end
    end else if (ld_start) begin
      m_load[i] = 1;
      m_n[i]    = 0;
      m_ovf[i]  = 0;
    end
  endfunction

  function automatic bit exp_busy(input int i);
    return (m_clear[i] > 0) || m_load[i] || m_done[i];
  endfunction

  function automatic logic [31:0] exp_data(input int i);
    int a = (i == 0) ? int'(addr) : int'(addr2);
    if (exp_busy(i)) return 0;
    return m_mem[i][a];
  endfunction

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  always @(negedge clk) if (ld_done === 1'b1) done_cnt++;

  // Per-cycle comparison of both instances against the model
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("busy",   32'(busy),      32'(exp_busy(0)));
      chk("ready",  32'(ld_ready),  32'(m_load[0]));
      chk("done",   32'(ld_done),   32'(m_done[0]));
      chk("ovf",    32'(ld_ovf),    32'(m_ovf[0]));
      chk("data",   32'(data),      exp_data(0));
      chk("busy2",  32'(busy2),     32'(exp_busy(1)));
      chk("ready2", 32'(ld_ready2), 32'(m_load[1]));
      chk("done2",  32'(ld_done2),  32'(m_done[1]));
      chk("ovf2",   32'(ld_ovf2),   32'(m_ovf[1]));
      chk("data2",  32'(data2),     exp_data(1));
    end
  end

  task automatic wait_idle(input string nm);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (busy !== 1'b0 && k < 2000);
    chk(nm, 32'(busy), 32'd0);
  endtask

  task automatic start_load();
    @(posedge clk); #1 ld_start = 1'b1;
    @(posedge clk); #1 ld_start = 1'b0;
  endtask

  task automatic send_bytes(input int n, input int gap_lo, input int gap_hi,
                            input bit with_last, input bit noise, input int rdy_from);
    for (int i = 0; i < n; i++) begin
      ld_valid = 1'b1;
      ld_byte  = stim[i];
      ld_last  = with_last && (i == n - 1);
      if (noise) begin
        ld_start = 1'($urandom_range(0, 1));
        addr     = 8'($urandom);
      end
      if (rdy_from >= 0 && i >= rdy_from) begin
        @(negedge clk);
        chk("ready_after_full", 32'(ld_ready), 32'd0);
      end
      @(posedge clk); #1;
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      ld_start = 1'b0;
      repeat ($urandom_range(gap_lo, gap_hi)) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic rd0(input string nm, input int a, input logic [31:0] e);
    @(posedge clk); #1 addr = 8'(a);
    @(negedge clk);
    chk(nm, 32'(data), e);
  endtask

  task automatic rd1(input string nm, input int a, input logic [31:0] e);
    @(posedge clk); #1 addr = 8'(a);
    @(negedge clk);
    chk(nm, 32'(data2), e);
  endtask

  initial begin
    int cyc;
    int d0;
    for (int i = 0; i < 2; i++) begin
      m_clear[i] = 0; m_load[i] = 0; m_done[i] = 0; m_ovf[i] = 0; m_n[i] = 0;
      for (int a = 0; a < 256; a++) m_mem[i][a] = 0;
    end
    reset = 1'b1; ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
    ld_byte = 8'h00; addr = 8'h00;

    // Reset values and clear duration
    repeat (3) begin
      @(negedge clk);
      chk("rst_busy",  32'(busy),     32'd1);
      chk("rst_ready", 32'(ld_ready), 32'd0);
      chk("rst_done",  32'(ld_done),  32'd0);
      chk("rst_ovf",   32'(ld_ovf),   32'd0);
      chk("rst_data",  32'(data),     32'd0);
    end
    @(posedge clk); #1 reset = 1'b0;
    cyc = 0;
    do begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end while (busy !== 1'b0 && cyc < 1000);
    chk("clear_cycles", 32'(cyc), 32'd256);
    rd0("clr_0", 0, 32'h0);
    rd0("clr_7f", 8'h7F, 32'h0);
    rd0("clr_ff", 8'hFF, 32'h0);

    // Two full words
    d0 = done_cnt;
    stim[0] = 8'h12; stim[1] = 8'h34; stim[2] = 8'hAB; stim[3] = 8'hCD;
    start_load();
    send_bytes(4, 0, 0, 1'b1, 1'b0, -1);
    wait_idle("idle_a");
    chk("done_once", 32'(done_cnt - d0), 32'd1);
    rd0("a_m0", 0, 32'h1234);
    rd0("a_m1", 1, 32'hABCD);
    rd0("a_m2", 2, 32'h0000);
    rd1("a_w0", 0, 32'h1234AB);
    rd1("a_w1", 1, 32'hCD0000);

    // Gapped bytes, padded final word
    stim[0] = 8'h56; stim[1] = 8'h78; stim[2] = 8'h9A;
    start_load();
    send_bytes(3, 3, 3, 1'b1, 1'b0, -1);
    wait_idle("idle_b");
    rd0("b_m0", 0, 32'h5678);
    rd0("b_m1", 1, 32'h9A00);
    rd1("b_w0", 0, 32'h56789A);

    // Six bytes: two 24-bit words on the narrow instance
    stim[0] = 8'h01; stim[1] = 8'h23; stim[2] = 8'h45;
    stim[3] = 8'h67; stim[4] = 8'h89; stim[5] = 8'hAB;
    start_load();
    send_bytes(6, 0, 1, 1'b1, 1'b0, -1);
    wait_idle("idle_c");
    rd1("c_w0", 0, 32'h012345);
    rd1("c_w1", 1, 32'h6789AB);
    rd0("c_m2", 2, 32'h89AB);

    // Random loads with stray ld_start and addr traffic during LOAD
    for (int t = 0; t < 20; t++) begin
      int n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++) stim[i] = 8'($urandom);
      start_load();
      send_bytes(n, 0, 2, 1'b1, 1'b1, -1);
      wait_idle("idle_rand");
      repeat (6) begin
        @(posedge clk); #1 addr = 8'($urandom);
        ld_valid = 1'($urandom_range(0, 1));
      end
      #0 ld_valid = 1'b0;
    end

    // Overflow: 514 bytes, no ld_last
    for (int i = 0; i < 514; i++) stim[i] = 8'($urandom);
    start_load();
    send_bytes(514, 0, 0, 1'b0, 1'b0, 512);
    wait_idle("idle_ovf");
    chk("ovf_flag",  32'(ld_ovf),  32'd1);
    chk("ovf_flag2", 32'(ld_ovf2), 32'd1);
    rd0("ovf_m255", 255, 32'({stim[510], stim[511]}));
    rd0("ovf_m0", 0, 32'({stim[0], stim[1]}));
    rd1("ovf_w15", 15, 32'({stim[45], stim[46], stim[47]}));

    // ld_start held during CLEAR is ignored
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    ld_start = 1'b1;
    repeat (8) begin @(posedge clk); #1; end
    ld_start = 1'b0;
    wait_idle("idle_clr_start");
    chk("clr_start_ready", 32'(ld_ready), 32'd0);
    chk("clr_start_ovf",   32'(ld_ovf),   32'd0);

    // Reset in the middle of a load
    d0 = done_cnt;
    stim[0] = 8'hDE; stim[1] = 8'hAD; stim[2] = 8'hBE;
    start_load();
    send_bytes(3, 0, 0, 1'b0, 1'b0, -1);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    wait_idle("idle_midrst");
    chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    rd0("midrst_m0", 0, 32'h0);
    rd0("midrst_m1", 1, 32'h0);
    rd1("midrst_w0", 0, 32'h0);
    for (int a = 0; a < 256; a++) begin
      @(posedge clk); #1 addr = 8'(a);
    end
    rd0("midrst_mff", 8'hFF, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
